// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: single-port data RAM controller.
// Decodes a select/operation opcode. Sources are RAM, ROM, REG and PC.
// Provides a registered read port with a valid strobe, an auto-incrementing
// pointer for streaming access, and a multi-cycle CLEAR sweep with a ready
// handshake.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous, active-high reset
//   opcode       - sel = [DATA_WIDTH-1 -: 4], op = [DATA_WIDTH-5 -: 4],
//                  [ADDR_WIDTH-1:0] = ROM-source address
//   operand      - direct address, or write data for the RAM source
//   write_data   - write data for the ROM and REG sources
//   read_enable  - read request qualifier
//   write_enable - write/command request qualifier
//   read_data    - registered read result, holds between reads
//   read_valid   - one-cycle pulse, read_data updated this cycle
//   ready        - 1 = accepting commands
//   dropped      - one-cycle pulse, an enabled command arrived while not ready
//   ptr          - current streaming pointer
module data_ram_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0] operand,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  ready,
  output logic                  dropped,
  output logic [ADDR_WIDTH-1:0] ptr
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  localparam logic [3:0] SEL_RAM = 4'h4;
  localparam logic [3:0] SEL_ROM = 4'h3;
  localparam logic [3:0] SEL_REG = 4'h9;
  localparam logic [3:0] SEL_PC  = 4'h7;

  localparam logic [3:0] OP_WRITE     = 4'h1;
  localparam logic [3:0] OP_READ      = 4'h2;
  localparam logic [3:0] OP_PTR_LOAD  = 4'h3;
  localparam logic [3:0] OP_WRITE_INC = 4'h4;
  localparam logic [3:0] OP_READ_INC  = 4'h5;
  localparam logic [3:0] OP_CLEAR     = 4'h6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;
  logic                    ready_q, ready_d;
  logic                    dropped_q, dropped_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;

  // Opcode field decode
  logic [3:0]            sel, op;
  logic                  is_ram, is_rom, is_reg, is_pc, sel_mem, sel_valid;
  logic [ADDR_WIDTH-1:0] dir_addr;
  logic [DATA_WIDTH-1:0] wr_src;
  logic                  cmd_any;

  assign sel       = opcode[DATA_WIDTH-1 -: 4];
  assign op        = opcode[DATA_WIDTH-5 -: 4];
  assign is_ram    = (sel == SEL_RAM);
  assign is_rom    = (sel == SEL_ROM);
  assign is_reg    = (sel == SEL_REG);
  assign is_pc     = (sel == SEL_PC);
  assign sel_mem   = is_ram | is_rom | is_reg;
  assign sel_valid = sel_mem | is_pc;
  assign dir_addr  = is_rom ? opcode[ADDR_WIDTH-1:0] : operand[ADDR_WIDTH-1:0];
  assign wr_src    = is_ram ? operand : write_data;
  assign cmd_any   = (read_enable | write_enable) & sel_valid;

  // Only part of opcode/operand feeds the decode for some parameter sets.
  logic unused_bits;
  assign unused_bits = ^{opcode, operand};

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      ready_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      ready_q   <= ready_d;
      dropped_q <= dropped_d;
    end
  end

  // Memory array: contents survive reset; writes are suppressed while reset is high
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Next-state, command decode and memory control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    ready_d   = ready_q;
    dropped_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = dir_addr;
    mem_wdata = wr_src;
    rd_en     = 1'b0;
    rd_addr   = dir_addr;

    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        // ready_q is low for the first cycle after reset; commands then are dropped
        if (ready_q) begin
          if (write_enable && sel_mem) begin
            case (op)
              OP_WRITE: begin
                mem_we = 1'b1;
              end
              OP_WRITE_INC: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                ptr_d     = ptr_q + ADDR_WIDTH'(1);
              end
              OP_PTR_LOAD: begin
                if (is_ram) begin
                  ptr_d = operand[ADDR_WIDTH-1:0];
                end
              end
              OP_CLEAR: begin
                if (is_ram) begin
                  state_d = ST_CLEAR;
                  cnt_d   = '0;
                  ready_d = 1'b0;
                end
              end
              default: ;
            endcase
          end
          if (read_enable) begin
            if (is_pc) begin
              rd_en = 1'b1;
            end else if (sel_mem && op == OP_READ) begin
              rd_en = 1'b1;
            end else if ((is_ram || is_reg) && op == OP_READ_INC) begin
              rd_en   = 1'b1;
              rd_addr = ptr_q;
              ptr_d   = ptr_q + ADDR_WIDTH'(1);
            end
          end
        end else if (cmd_any) begin
          dropped_d = 1'b1;
        end
      end

      ST_CLEAR: begin
        ready_d   = 1'b0;
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + ADDR_WIDTH'(1);
        dropped_d = cmd_any;
        // Last word of the sweep: return to IDLE with ready and a fresh pointer
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rd_en) begin
      rvalid_d = 1'b1;
      rdata_d  = mem[rd_addr];
    end
  end

  assign read_data  = rdata_q;
  assign read_valid = rvalid_q;
  assign ready      = ready_q;
  assign dropped    = dropped_q;
  assign ptr        = ptr_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed testbench for data_ram_ctrl at DATA_WIDTH=16, ADDR_WIDTH=8.
module tb_data_ram_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] opcode = '0;
  logic [15:0] operand = '0;
  logic [15:0] write_data = '0;
  logic        read_enable = 1'b0;
  logic        write_enable = 1'b0;
  logic [15:0] read_data;
  logic        read_valid;
  logic        ready;
  logic        dropped;
  logic [7:0]  ptr;

  int checks = 0;
  int fails  = 0;

  data_ram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .operand(operand),
    .write_data(write_data), .read_enable(read_enable), .write_enable(write_enable),
    .read_data(read_data), .read_valid(read_valid), .ready(ready),
    .dropped(dropped), .ptr(ptr)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle command; outputs are sampled 1 time unit after the edge
  task automatic drive(input logic [15:0] oc, input logic [15:0] od,
                       input logic [15:0] wd, input logic re, input logic we);
    opcode = oc; operand = od; write_data = wd;
    read_enable = re; write_enable = we;
    cyc();
    read_enable = 1'b0; write_enable = 1'b0;
  endtask

  task automatic rd(input logic [15:0] addr);
    drive(16'h4200, addr, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (read_valid !== 1'b0 || dropped !== 1'b0) begin fails++; $display("FAIL reset_strobes got rv=%b dr=%b want 0 0", read_valid, dropped); end
    checks++; if (ptr !== 8'h00 || read_data !== 16'h0000) begin fails++; $display("FAIL reset_regs got ptr=%h rd=%h want 00 0000", ptr, read_data); end
    reset = 1'b0;
    cyc();
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %b want 1", ready); end
  endtask

  task automatic test_ram_reg_write_read();
    drive(16'h4100, 16'h0012, 16'h0000, 1'b0, 1'b1);
    drive(16'h9100, 16'h0005, 16'hBEEF, 1'b0, 1'b1);
    rd(16'h0005);
    checks++; if (read_valid !== 1'b1 || read_data !== 16'hBEEF) begin fails++; $display("FAIL reg_read got rv=%b %h want 1 beef", read_valid, read_data); end
    cyc();
    checks++; if (read_valid !== 1'b0 || read_data !== 16'hBEEF) begin fails++; $display("FAIL read_hold got rv=%b %h want 0 beef", read_valid, read_data); end
    rd(16'h0012);
    checks++; if (read_data !== 16'h0012) begin fails++; $display("FAIL ram_read got %h want 0012", read_data); end
  endtask

  task automatic test_rom_pc();
    drive(16'h3133, 16'h0000, 16'h1234, 1'b0, 1'b1);
    drive(16'h7000, 16'h0033, 16'h0000, 1'b1, 1'b0);
    checks++; if (read_valid !== 1'b1 || read_data !== 16'h1234) begin fails++; $display("FAIL pc_read got rv=%b %h want 1 1234", read_valid, read_data); end
  endtask

  task automatic test_ptr_inc();
    logic [15:0] vals [3];
    logic [7:0]  ptrs [3];
    vals[0] = 16'hA1A1; vals[1] = 16'hB2B2; vals[2] = 16'hC3C3;
    ptrs[0] = 8'hFF;    ptrs[1] = 8'h00;    ptrs[2] = 8'h01;
    drive(16'h4300, 16'h00FE, 16'h0000, 1'b0, 1'b1);
    checks++; if (ptr !== 8'hFE) begin fails++; $display("FAIL ptr_load got %h want fe", ptr); end
    for (int i = 0; i < 3; i++) begin
      drive(16'h9400, 16'h0000, vals[i], 1'b0, 1'b1);
      checks++; if (ptr !== ptrs[i]) begin fails++; $display("FAIL write_inc_ptr%0d got %h want %h", i, ptr, ptrs[i]); end
    end
    drive(16'h4300, 16'h00FE, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(16'h4500, 16'h0000, 16'h0000, 1'b1, 1'b0);
      checks++; if (read_valid !== 1'b1 || read_data !== vals[i] || ptr !== ptrs[i]) begin
        fails++; $display("FAIL read_inc%0d got rv=%b %h ptr=%h want 1 %h %h", i, read_valid, read_data, ptr, vals[i], ptrs[i]);
      end
    end
    // ROM source does not support READ_INC
    drive(16'h3500, 16'h0000, 16'h0000, 1'b1, 1'b0);
    checks++; if (read_valid !== 1'b0 || ptr !== 8'h01) begin fails++; $display("FAIL rom_read_inc got rv=%b ptr=%h want 0 01", read_valid, ptr); end
  endtask

  task automatic test_back_to_back();
    drive(16'h9100, 16'h0040, 16'hABCD, 1'b0, 1'b1);
    drive(16'h9200, 16'h0040, 16'h0000, 1'b1, 1'b0);
    checks++; if (read_data !== 16'hABCD) begin fails++; $display("FAIL b2b_read got %h want abcd", read_data); end
    // Both enables with a WRITE op: write happens, no read strobe
    drive(16'h9100, 16'h0041, 16'h1357, 1'b1, 1'b1);
    checks++; if (read_valid !== 1'b0) begin fails++; $display("FAIL both_en_write_rv got %b want 0", read_valid); end
    drive(16'h9200, 16'h0041, 16'h0000, 1'b1, 1'b1);
    checks++; if (read_valid !== 1'b1 || read_data !== 16'h1357) begin fails++; $display("FAIL both_en_read got rv=%b %h want 1 1357", read_valid, read_data); end
  endtask

  task automatic test_unknown();
    drive(16'h5100, 16'h0005, 16'h1111, 1'b1, 1'b1);
    checks++; if (read_valid !== 1'b0 || dropped !== 1'b0) begin fails++; $display("FAIL unk_sel got rv=%b dr=%b want 0 0", read_valid, dropped); end
    drive(16'h4F00, 16'h0005, 16'h2222, 1'b1, 1'b1);
    checks++; if (read_valid !== 1'b0 || dropped !== 1'b0) begin fails++; $display("FAIL unk_op got rv=%b dr=%b want 0 0", read_valid, dropped); end
    rd(16'h0005);
    checks++; if (read_data !== 16'hBEEF) begin fails++; $display("FAIL unk_mem5 got %h want beef", read_data); end
    rd(16'h0000);
    checks++; if (read_data !== 16'hC3C3) begin fails++; $display("FAIL unk_mem0 got %h want c3c3", read_data); end
  endtask

  task automatic test_clear();
    int n;
    drive(16'h9100, 16'h0080, 16'h5555, 1'b0, 1'b1);
    drive(16'h4600, 16'h0000, 16'h0000, 1'b0, 1'b1);
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL clear_start_ready got %b want 0", ready); end
    n = 0;
    while (ready !== 1'b1 && n < 300) begin
      if (n == 100) begin opcode = 16'h4200; operand = 16'h0080; read_enable = 1'b1; end
      cyc();
      n++;
      if (n == 101) begin
        read_enable = 1'b0;
        checks++; if (dropped !== 1'b1 || read_valid !== 1'b0) begin fails++; $display("FAIL clear_drop got dr=%b rv=%b want 1 0", dropped, read_valid); end
      end
    end
    checks++; if (n != 256) begin fails++; $display("FAIL clear_len got %0d want 256", n); end
    checks++; if (ptr !== 8'h00 || dropped !== 1'b0) begin fails++; $display("FAIL clear_exit got ptr=%h dr=%b want 00 0", ptr, dropped); end
    rd(16'h0000);
    checks++; if (read_data !== 16'h0000) begin fails++; $display("FAIL clear_mem00 got %h want 0000", read_data); end
    rd(16'h0080);
    checks++; if (read_data !== 16'h0000) begin fails++; $display("FAIL clear_mem80 got %h want 0000", read_data); end
    rd(16'h00FF);
    checks++; if (read_data !== 16'h0000) begin fails++; $display("FAIL clear_memff got %h want 0000", read_data); end
  endtask

  task automatic test_reset_mid_clear();
    drive(16'h9100, 16'h0000, 16'h0C0C, 1'b0, 1'b1);
    drive(16'h9100, 16'h0009, 16'h9999, 1'b0, 1'b1);
    drive(16'h9100, 16'h0020, 16'h7777, 1'b0, 1'b1);
    drive(16'h4300, 16'h0033, 16'h0000, 1'b0, 1'b1);
    drive(16'h4600, 16'h0000, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc();
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL mid_sweep_ready got %b want 0", ready); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++; if (ptr !== 8'h00 || read_valid !== 1'b0 || ready !== 1'b0) begin fails++; $display("FAIL abort_regs got ptr=%h rv=%b rdy=%b want 00 0 0", ptr, read_valid, ready); end
    cyc();
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL abort_ready got %b want 1", ready); end
    rd(16'h0000);
    checks++; if (read_data !== 16'h0000) begin fails++; $display("FAIL abort_mem00 got %h want 0000", read_data); end
    rd(16'h0009);
    checks++; if (read_data !== 16'h0000) begin fails++; $display("FAIL abort_mem09 got %h want 0000", read_data); end
    rd(16'h0020);
    checks++; if (read_data !== 16'h7777) begin fails++; $display("FAIL abort_mem20 got %h want 7777", read_data); end
  endtask

  initial begin
    test_reset();
    test_ram_reg_write_read();
    test_rom_pc();
    test_ptr_inc();
    test_back_to_back();
    test_unknown();
    test_clear();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/data_ram_ctrl.md
Name: data_ram_ctrl

Overview:
Parametrised successor to the processor's single-port data RAM. Decodes the shared 16-bit-style opcode (select nibble plus operation nibble) and services RAM, ROM, REG and PC sources. Replaces tri-state read drive with a registered read port plus valid strobe. Adds an auto-incrementing pointer for indirect/streaming access and a multi-cycle memory CLEAR sweep with a ready handshake.

Parameters:
DATA_WIDTH, 16, word width of opcode, operand, write_data and read_data; must be >= 16.
ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words; must be 1..8.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
opcode  in  DATA_WIDTH  sel = opcode[DATA_WIDTH-1 -: 4], op = opcode[DATA_WIDTH-5 -: 4], opcode[7:0] = ROM-source address
operand  in  DATA_WIDTH  address (operand[ADDR_WIDTH-1:0]) or write data (RAM_OP)
write_data  in  DATA_WIDTH  write data for ROM_OP / REG_OP sources
read_enable  in  1  read request qualifier
write_enable  in  1  write/command request qualifier
read_data  out  DATA_WIDTH  registered read result
read_valid  out  1  one-cycle pulse: read_data updated this cycle
ready  out  1  1 = accepting commands; 0 during CLEAR sweep or reset
dropped  out  1  one-cycle pulse: enabled command arrived while ready = 0
ptr  out  ADDR_WIDTH  current pointer value (debug/observe)

Behaviour:
- Select codes: RAM_OP 4'h4, ROM_OP 4'h3, REG_OP 4'h9, PC_OP 4'h7; any other sel -> no action, no dropped.
- Op codes: 1 WRITE, 2 READ, 3 PTR_LOAD, 4 WRITE_INC, 5 READ_INC, 6 CLEAR; others -> no action.
- Direct address: ROM_OP uses opcode[ADDR_WIDTH-1:0]; all others use operand[ADDR_WIDTH-1:0].
- Write source: RAM_OP writes operand; ROM_OP and REG_OP write write_data; PC_OP never writes.
- WRITE (write_enable=1, sel RAM/ROM/REG): mem[addr] <= data at clock edge.
- READ (read_enable=1, sel RAM/ROM/REG, op 2) or PC_OP with read_enable=1 and any op: read_data <= mem[addr] next edge; read_valid=1 that cycle. Latency exactly 1 cycle.
- PTR_LOAD (write_enable=1, sel RAM_OP): ptr <= operand[ADDR_WIDTH-1:0].
- WRITE_INC (write_enable=1, sel RAM/ROM/REG): mem[ptr] <= data; ptr <= ptr+1 mod DEPTH (DEPTH-1 wraps to 0).
- READ_INC (read_enable=1, sel RAM/REG): read mem[ptr] as READ; ptr <= ptr+1 mod DEPTH.
- Pointer increments only on a qualifying, accepted command; non-qualifying enable leaves ptr unchanged.
- read_enable and write_enable both high: op decides; WRITE/WRITE_INC ignore read_enable, READ/READ_INC ignore write_enable. No read-before-write hazard across cycles: write at edge N visible to a read issued at cycle N+1.
- read_data holds last value when read_valid=0.
- FSM: IDLE, CLEAR.
  IDLE: ready=1; CLEAR command (write_enable=1, sel RAM_OP, op 6) -> CLEAR, cnt <= 0.
  CLEAR: ready=0; each cycle mem[cnt] <= 0, cnt++; after writing DEPTH-1 -> IDLE. ready low for exactly DEPTH cycles; ptr reset to 0 on exit.
  In CLEAR any read_enable/write_enable with valid sel -> dropped=1 for that cycle, command discarded, no state change.
- Reset (sync, any state incl. mid-CLEAR): state IDLE, cnt 0, ptr 0, read_data 0, read_valid 0, dropped 0, ready 0 while reset high, 1 the first cycle after. Memory contents not reset; an aborted CLEAR leaves memory partially zeroed.
- No $display in synthesisable path.

Test Plan:
- RAM_OP WRITE opcode 16'h4100, operand 16'h0012 -> wait; REG_OP WRITE opcode 16'h9100, operand 16'h0005, write_data 16'hBEEF -> READ opcode 16'h4200 operand 16'h0005: read_valid next cycle, read_data 16'hBEEF.
- ROM_OP WRITE opcode 16'h3133, write_data 16'h1234 -> PC_OP read opcode 16'h7000 operand 16'h0033: read_data 16'h1234 after 1 cycle.
- PTR_LOAD operand 16'h00FE, WRITE_INC x3 (data A,B,C) -> ptr 0xFF, 0x00, 0x01; READ_INC from ptr loaded 0xFE returns A, B, C at addrs FE, FF, 00.
- CLEAR at ADDR_WIDTH=8 -> ready low exactly 256 cycles; READ issued mid-sweep gives dropped=1, no read_valid; afterwards reads of 0x00, 0x80, 0xFF return 0, ptr 0.
- reset asserted at sweep cycle 10 -> next cycle ready=1 after release, ptr 0, read_valid 0; addr 0x00..0x09 zero, addr 0x20 retains prior value.
- Unknown sel 16'h5100 or op 16'h4F00 with both enables -> no memory change, no read_valid, no dropped.
